mc_maindec: RTL

//  Main control FSM for the multicycle MIPS core (Moore outputs, one gated Mealy term).

---
 rtl/mc_maindec.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mc_maindec.sv
// Main control FSM for the multicycle MIPS core.
// Moore outputs decoded from the current state; the only input-gated outputs
// are irwrite/pcwrite in FETCH (gated by mem_ready) and illegal_op in DECODE.
module mc_maindec #(
  parameter int OP_W        = 6,
  parameter bit SUPPORT_ORI = 1'b1,
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            memwrite,
  output logic            iord,
  output logic            irwrite,
  output logic            pcwrite,
  output logic            branch,
  output logic            bne,
  output logic            regdst,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic [1:0]      aluop,
  output logic [3:0]      state,
  output logic            illegal_op
);

  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11,
    ORIEX   = 4'd12,
    BNEEX   = 4'd13
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register; reset forces FETCH immediately, which also drops any
  // pending memwrite/regwrite since all outputs decode from state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = FETCH;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        if (op == OP_LW || op == OP_SW)        state_d = MEMADR;
        else if (op == OP_RTYPE)               state_d = RTYPEEX;
        else if (op == OP_BEQ)                 state_d = BEQEX;
        else if (op == OP_BNE && SUPPORT_BNE)  state_d = BNEEX;
        else if (op == OP_ADDI)                state_d = ADDIEX;
        else if (op == OP_ORI && SUPPORT_ORI)  state_d = ORIEX;
        else if (op == OP_J)                   state_d = JEX;
        else begin
          state_d    = FETCH;
          illegal_op = 1'b1;
        end
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = FETCH;
      end
      BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        bne     = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = IMMWB;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
        state_d = IMMWB;
      end
      IMMWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign state = state_q;

endmodule
